mem_sram_stage: RTL and testbench

MEM_SRAM_STAGE -- requirements
Module: mem_sram_stage

---
 rtl/mem_pkg.sv | 24 ++
 rtl/sram_ctrl.sv | 103 ++++++++++
 rtl/mem_sram_stage.sv | 78 +++++++
 tb/tb_mem_sram_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage and its 16-bit SRAM controller.
package mem_pkg;

  // Access sequencer states: low half, high half, then a one-cycle release.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } sram_state_t;

  localparam logic [31:0] DATA_BASE_DEFAULT = 32'd1024;
  localparam int          SRAM_ADDR_W       = 18;
  localparam int          SRAM_DATA_W       = 16;
  localparam int          WORD_IDX_W        = SRAM_ADDR_W - 1;
  localparam int          WAIT_CNT_W        = 4;

  // Byte address -> 32-bit word slot in SRAM; addresses outside the SRAM wrap.
  function automatic logic [WORD_IDX_W-1:0] word_index(input logic [31:0] byte_addr,
                                                       input logic [31:0] base);
    return WORD_IDX_W'((byte_addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Two-phase 16-bit SRAM sequencer: one 32-bit word = low half then high half.
module sram_ctrl
  import mem_pkg::*;
#(
  parameter int SRAM_WAIT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   is_write,
  input  logic [WORD_IDX_W-1:0]  word_idx,
  input  logic [31:0]            wr_data,
  output logic                   in_idle,
  output logic                   in_done,
  output logic [31:0]            rd_data,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  inout  wire  [SRAM_DATA_W-1:0] sram_dq,
  output logic                   sram_we_n
);

  localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(SRAM_WAIT - 1);

  sram_state_t            state_reg, state_next;
  logic [WAIT_CNT_W-1:0]  cnt_reg, cnt_next;
  logic [SRAM_DATA_W-1:0] lo_reg, hi_reg;
  logic [SRAM_DATA_W-1:0] dq_out;
  logic                   phase_last;
  logic                   in_phase;
  logic                   dq_oe;

  assign phase_last = (cnt_reg == LAST_CNT);
  assign in_phase   = (state_reg == LO) || (state_reg == HI);
  assign in_idle    = (state_reg == IDLE);
  assign in_done    = (state_reg == DONE);

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state: each half-phase runs SRAM_WAIT cycles, counter restarts per phase.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (req) state_next = LO;
      end
      LO: begin
        if (phase_last) begin
          state_next = HI;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + WAIT_CNT_W'(1);
        end
      end
      HI: begin
        if (phase_last) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + WAIT_CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Read half latches: sample the bus on the final cycle of each phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_reg <= '0;
      hi_reg <= '0;
    end else if (in_phase && !is_write && phase_last) begin
      if (state_reg == LO) lo_reg <= sram_dq;
      else                 hi_reg <= sram_dq;
    end
  end

  // Pin drive: data held for the whole phase, strobe released on its last
  // cycle so the rising edge of we_n lands while data is still valid.
  assign dq_oe     = in_phase && is_write;
  assign dq_out    = (state_reg == HI) ? wr_data[31:16] : wr_data[15:0];
  assign sram_dq   = dq_oe ? dq_out : {SRAM_DATA_W{1'bz}};
  assign sram_we_n = !(dq_oe && !phase_last);
  assign sram_addr = {word_idx, (state_reg == HI)};
  assign rd_data   = {hi_reg, lo_reg};

endmodule

// File: rtl/mem_sram_stage.sv
// MEM pipeline stage: request decode, SRAM stall control and the MEM/WB register.
module mem_sram_stage
  import mem_pkg::*;
#(
  parameter int          SRAM_WAIT = 2,
  parameter logic [31:0] DATA_BASE = DATA_BASE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   WB_en_in,
  input  logic [1:0]             MEM_Signal_in,
  input  logic [4:0]             dest_in,
  input  logic [31:0]            ALU_result_in,
  input  logic [31:0]            reg2_in,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  inout  wire  [SRAM_DATA_W-1:0] sram_dq,
  output logic                   sram_we_n,
  output logic                   WB_en_MEM,
  output logic                   MEM_R_en_MEM,
  output logic [4:0]             dest_MEM,
  output logic [31:0]            ALU_result_MEM,
  output logic [31:0]            mem_data_MEM
);

  logic                  is_read;
  logic                  is_write;
  logic                  req;
  logic                  in_idle;
  logic                  in_done;
  logic [31:0]           rd_data;
  logic [WORD_IDX_W-1:0] word_idx;

  // Both enables set together is treated as no access.
  assign is_read  = (MEM_Signal_in == 2'b10);
  assign is_write = (MEM_Signal_in == 2'b01);
  assign req      = is_read || is_write;
  assign word_idx = word_index(ALU_result_in, DATA_BASE);
  assign ready    = in_done || (in_idle && !req);

  sram_ctrl #(
    .SRAM_WAIT (SRAM_WAIT)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .is_write  (is_write),
    .word_idx  (word_idx),
    .wr_data   (reg2_in),
    .in_idle   (in_idle),
    .in_done   (in_done),
    .rd_data   (rd_data),
    .sram_addr (sram_addr),
    .sram_dq   (sram_dq),
    .sram_we_n (sram_we_n)
  );

  // MEM/WB register: load on ready, otherwise insert a bubble so WB never repeats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WB_en_MEM      <= 1'b0;
      MEM_R_en_MEM   <= 1'b0;
      dest_MEM       <= '0;
      ALU_result_MEM <= '0;
      mem_data_MEM   <= '0;
    end else if (ready) begin
      WB_en_MEM      <= WB_en_in;
      MEM_R_en_MEM   <= MEM_Signal_in[1];
      dest_MEM       <= dest_in;
      ALU_result_MEM <= ALU_result_in;
      mem_data_MEM   <= is_read ? rd_data : 32'd0;
    end else begin
      WB_en_MEM    <= 1'b0;
      MEM_R_en_MEM <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_sram_stage.sv
// Self-checking bench for mem_sram_stage with a pin-level SRAM and a word-level reference.
module tb_mem_sram_stage;

  localparam int          W    = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_en_in;
  logic [1:0]  MEM_Signal_in;
  logic [4:0]  dest_in;
  logic [31:0] ALU_result_in;
  logic [31:0] reg2_in;
  logic        ready;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n;
  logic        WB_en_MEM;
  logic        MEM_R_en_MEM;
  logic [4:0]  dest_MEM;
  logic [31:0] ALU_result_MEM;
  logic [31:0] mem_data_MEM;

  always #5 clk = ~clk;

  mem_sram_stage #(.SRAM_WAIT(W), .DATA_BASE(BASE)) dut (
    .clk            (clk),
    .rst            (rst),
    .WB_en_in       (WB_en_in),
    .MEM_Signal_in  (MEM_Signal_in),
    .dest_in        (dest_in),
    .ALU_result_in  (ALU_result_in),
    .reg2_in        (reg2_in),
    .ready          (ready),
    .sram_addr      (sram_addr),
    .sram_dq        (sram_dq),
    .sram_we_n      (sram_we_n),
    .WB_en_MEM      (WB_en_MEM),
    .MEM_R_en_MEM   (MEM_R_en_MEM),
    .dest_MEM       (dest_MEM),
    .ALU_result_MEM (ALU_result_MEM),
    .mem_data_MEM   (mem_data_MEM)
  );

  // Pin-level asynchronous SRAM: data commits on the rising edge of we_n;
  // a pulse cut short by reset is an aborted write.
  logic [15:0] sram_mem [0:262143];
  logic        we_prev = 1'b1;
  logic        tb_drive;
  assign tb_drive = (MEM_Signal_in == 2'b10);
  assign sram_dq  = tb_drive ? sram_mem[sram_addr] : 16'hzzzz;

  always @(negedge clk) begin
    if (rst && sram_we_n && !we_prev) sram_mem[sram_addr] <= sram_dq;
    we_prev <= sram_we_n;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [16:0] widx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) / 4;
    return off[16:0];
  endfunction

  // Reference model state: current instruction and expected MEM/WB contents.
  logic        chk_en = 1'b1;
  logic        active = 1'b0;
  int          cyc;
  int          low_cnt;
  int          we_low_cnt;
  logic [17:0] wr_addrs[$];
  logic        cur_wb;
  logic [1:0]  cur_sig;
  logic [4:0]  cur_dest;
  logic [31:0] cur_alu, cur_r2;
  logic        exp_wb = 1'b0, exp_r = 1'b0;
  logic [4:0]  exp_dest = '0;
  logic [31:0] exp_alu = '0, exp_data = '0;
  logic [31:0] ref_mem [logic [16:0]];

  logic        c_req, c_wr, c_rd, c_lo, c_hi, c_rdy;
  logic [16:0] c_ix;

  // Compare process: an access holds ready low for the request cycle plus
  // two phases of W cycles, then one ready cycle commits it.
  always @(negedge clk) begin
    if (chk_en && active) begin
      c_req = (cur_sig == 2'b10) || (cur_sig == 2'b01);
      c_wr  = (cur_sig == 2'b01);
      c_rd  = (cur_sig == 2'b10);
      c_lo  = c_req && cyc >= 1 && cyc <= W;
      c_hi  = c_req && cyc > W && cyc <= 2 * W;
      c_rdy = !c_req || cyc == 2 * W + 1;
      c_ix  = widx(cur_alu);

      chk("ready", ready, c_rdy);
      if (c_lo || c_hi) chk("sram_addr", sram_addr, {c_ix, c_hi});
      if (c_wr && (c_lo || c_hi)) begin
        chk("sram_dq", sram_dq, c_lo ? cur_r2[15:0] : cur_r2[31:16]);
        chk("sram_we_n", sram_we_n, (cyc == W) || (cyc == 2 * W));
      end else begin
        chk("sram_we_n_idle", sram_we_n, 1'b1);
      end
      chk("dq_drive", dut.u_ctrl.dq_oe, c_wr && (c_lo || c_hi));
      chk("WB_en_MEM", WB_en_MEM, exp_wb);
      chk("MEM_R_en_MEM", MEM_R_en_MEM, exp_r);
      chk("dest_MEM", dest_MEM, exp_dest);
      chk("ALU_result_MEM", ALU_result_MEM, exp_alu);
      chk("mem_data_MEM", mem_data_MEM, exp_data);

      if (!ready) low_cnt++;
      if (!sram_we_n) begin
        we_low_cnt++;
        wr_addrs.push_back(sram_addr);
      end

      if (c_rdy) begin
        exp_wb   = cur_wb;
        exp_r    = cur_sig[1];
        exp_dest = cur_dest;
        exp_alu  = cur_alu;
        exp_data = 32'd0;
        if (c_rd) exp_data = ref_mem.exists(c_ix) ? ref_mem[c_ix] : 32'd0;
        if (c_wr) ref_mem[c_ix] = cur_r2;
        active = 1'b0;
      end else begin
        exp_wb = 1'b0;
        exp_r  = 1'b0;
      end
      cyc++;
    end
  end

  // Present one instruction just after a clock edge and hold it until the
  // model says the stage advanced; returns 1 time unit after that edge.
  task automatic do_instr(input logic wb, input logic [1:0] sig, input logic [4:0] d,
                          input logic [31:0] alu, input logic [31:0] r2);
    int n;
    WB_en_in      = wb;
    MEM_Signal_in = sig;
    dest_in       = d;
    ALU_result_in = alu;
    reg2_in       = r2;
    cur_wb = wb; cur_sig = sig; cur_dest = d; cur_alu = alu; cur_r2 = r2;
    cyc = 0; low_cnt = 0; we_low_cnt = 0;
    wr_addrs.delete();
    active = 1'b1;
    n = 0;
    while (active && n < 64) begin
      @(posedge clk);
      n++;
    end
    if (active) begin
      chk("advance_timeout", active, 1'b0);
      active = 1'b0;
    end
    #1;
    $display("txn sig=%b wb=%b dest=%0d alu=%h r2=%h stall=%0d", sig, wb, d, alu, r2, low_cnt);
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0000;
    rst = 1'b0;
    WB_en_in = 1'b0; MEM_Signal_in = 2'b00; dest_in = '0; ALU_result_in = '0; reg2_in = '0;

    // Reset state.
    #3;
    chk("rst_ready_noreq", ready, 1'b1);
    chk("rst_we_n", sram_we_n, 1'b1);
    chk("rst_dq_drive", dut.u_ctrl.dq_oe, 1'b0);
    chk("rst_WB_en_MEM", WB_en_MEM, 1'b0);
    chk("rst_ALU_result_MEM", ALU_result_MEM, 32'd0);
    chk("rst_mem_data_MEM", mem_data_MEM, 32'd0);
    MEM_Signal_in = 2'b01;
    #1;
    chk("rst_ready_req", ready, 1'b0);
    MEM_Signal_in = 2'b00;
    #8 rst = 1'b1;
    @(posedge clk);
    #1;

    // Non-memory op passes straight through.
    do_instr(1'b1, 2'b00, 5'd3, 32'd7, 32'h0);
    chk("nomem_ALU_result_MEM", ALU_result_MEM, 32'd7);
    chk("nomem_WB_en_MEM", WB_en_MEM, 1'b1);
    chk("nomem_stall", low_cnt, 0);
    chk("nomem_strobes", we_low_cnt, 0);

    // Word write at 1028, then back-to-back read of it.
    do_instr(1'b0, 2'b01, 5'd0, 32'd1028, 32'hDEADBEEF);
    chk("wr_stall", low_cnt, 5);
    chk("wr_strobe_cycles", we_low_cnt, 2);
    chk("wr_addr_first", wr_addrs[0], 18'd2);
    chk("wr_addr_last", wr_addrs[wr_addrs.size() - 1], 18'd3);
    chk("sram_word2", sram_mem[2], 16'hBEEF);
    chk("sram_word3", sram_mem[3], 16'hDEAD);

    do_instr(1'b1, 2'b10, 5'd9, 32'd1028, 32'h0);
    chk("rd_mem_data", mem_data_MEM, 32'hDEADBEEF);
    chk("rd_MEM_R_en", MEM_R_en_MEM, 1'b1);
    chk("rd_dest", dest_MEM, 5'd9);
    chk("rd_stall", low_cnt, 5);

    // Both enables set: no access.
    do_instr(1'b1, 2'b11, 5'd4, 32'd1028, 32'h12345678);
    chk("both_stall", low_cnt, 0);
    chk("both_strobes", we_low_cnt, 0);
    chk("both_mem_data", mem_data_MEM, 32'd0);

    // Reset during the high phase of a write.
    do_instr(1'b0, 2'b01, 5'd0, 32'd1028, 32'h11112222);
    WB_en_in = 1'b0; MEM_Signal_in = 2'b01; dest_in = 5'd0;
    ALU_result_in = 32'd1028; reg2_in = 32'hAAAABBBB;
    repeat (3) @(posedge clk);
    #2;
    chk("hi_addr", sram_addr, 18'd3);
    chk("hi_dq", sram_dq, 16'hAAAA);
    chk("hi_we_n", sram_we_n, 1'b0);
    #5 rst = 1'b0;
    #1;
    chk("abort_we_n", sram_we_n, 1'b1);
    chk("abort_dq_drive", dut.u_ctrl.dq_oe, 1'b0);
    chk("abort_ready_req", ready, 1'b0);
    chk("abort_WB_en_MEM", WB_en_MEM, 1'b0);
    chk("abort_dest_MEM", dest_MEM, 5'd0);
    chk("abort_ALU_result_MEM", ALU_result_MEM, 32'd0);
    MEM_Signal_in = 2'b00; ALU_result_in = 32'd0; reg2_in = 32'd0;
    #1;
    chk("abort_ready_noreq", ready, 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    exp_wb = 1'b0; exp_r = 1'b0; exp_dest = '0; exp_alu = '0; exp_data = '0;
    ref_mem[widx(32'd1028)] = {16'h1111, 16'hBBBB};
    do_instr(1'b1, 2'b10, 5'd17, 32'd1028, 32'h0);
    chk("partial_word", mem_data_MEM, 32'h1111BBBB);

    // Randomized instruction stream, including wrapped out-of-range addresses.
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      do_instr(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
               a, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
